// File: rtl/timer_key_ctrl.sv
// timer_key_ctrl: front-panel control for the ramen timer.
// Synchronises and debounces the start/pause and clear keys, runs the
// IDLE/RUN/PAUSE/DONE machine, and drives the count enable, the clear
// pulse and the blinking alarm into the counter and display path.
module timer_key_ctrl #(
    parameter int DEB_CYCLES   = 200,
    parameter int BLINK_CYCLES = 2500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] key_n,
    input  logic       timeup,
    output logic       run,
    output logic       clr,
    output logic [1:0] state,
    output logic       alarm
);

    localparam int DW = $clog2(DEB_CYCLES);
    localparam int BW = $clog2(BLINK_CYCLES);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    // The synchroniser carries the inverted (pressed) level so that its
    // reset value of 0 means "not pressed".
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    stable_q, stable_prev_q;
    logic [1:0]    press_q;
    logic [DW-1:0] deb_cnt_q [2];
    logic          timeup_q;

    state_t        state_q, state_d;
    logic          clr_q, clr_d;
    logic          alarm_q, alarm_d;
    logic [BW-1:0] blink_q, blink_d;

    // Key synchronisers, per-key debounce, press-edge detection and timeup sampling
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q       <= 2'b00;
            sync2_q       <= 2'b00;
            stable_q      <= 2'b00;
            stable_prev_q <= 2'b00;
            press_q       <= 2'b00;
            deb_cnt_q[0]  <= '0;
            deb_cnt_q[1]  <= '0;
            timeup_q      <= 1'b0;
        end else begin
            sync1_q       <= ~key_n;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;
            timeup_q      <= timeup;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != stable_q[i]) begin
                    if (deb_cnt_q[i] == DEB_LAST) begin
                        stable_q[i]  <= ~stable_q[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
        end
    end

    // State register together with the registered clr and alarm outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            clr_q   <= 1'b0;
            alarm_q <= 1'b0;
            blink_q <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            alarm_q <= alarm_d;
            blink_q <= blink_d;
        end
    end

    // Next-state logic: timeup outranks keys, and KEY1 outranks KEY0 where both act
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press_q[1]) begin
                    clr_d = 1'b1;
                end else if (press_q[0]) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (timeup_q) begin
                    state_d = S_DONE;
                end else if (press_q[0]) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (press_q[1]) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                end else if (press_q[0]) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                if (|press_q) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                end
            end
        endcase
    end

    // Outputs: run decoded from the state register; alarm blinks only while in DONE
    always_comb begin
        alarm_d = 1'b0;
        blink_d = '0;
        if (state_d == S_DONE) begin
            if (state_q != S_DONE) begin
                alarm_d = 1'b1;
            end else if (blink_q == BLINK_LAST) begin
                alarm_d = ~alarm_q;
            end else begin
                alarm_d = alarm_q;
                blink_d = blink_q + 1'b1;
            end
        end
        run   = (state_q == S_RUN);
        clr   = clr_q;
        state = state_q;
        alarm = alarm_q;
    end

endmodule

// File: tb/tb_timer_key_ctrl.sv
// Bench for timer_key_ctrl: directed scenarios plus random key/timeup
// traffic, every cycle compared against a behavioural model.
module tb_timer_key_ctrl;

    localparam int DEB   = 4;
    localparam int BLINK = 3;
    localparam int IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key_n = 2'b11;
    logic       timeup = 1'b0;
    logic       run, clr, alarm;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;
    int clr_seen;

    timer_key_ctrl #(.DEB_CYCLES(DEB), .BLINK_CYCLES(BLINK)) dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .timeup(timeup),
        .run(run), .clr(clr), .state(state), .alarm(alarm)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [1:0] pipe [$];   // pressed levels travelling through the synchroniser
    logic [1:0] shist [$];  // synchronised levels seen at the most recent edges
    logic [1:0] m_stable, m_rose, m_ev;
    logic       m_tu, m_clr;
    int         m_state, m_age;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [1:0] k, input logic t);
        logic [1:0] synced, nstable;
        int ns;
        logic c;
        bit all_diff;
        if (!r) begin
            pipe = '{2'b00, 2'b00};
            shist.delete();
            m_stable = 2'b00; m_rose = 2'b00; m_ev = 2'b00;
            m_tu = 1'b0; m_clr = 1'b0; m_state = IDLE; m_age = 0;
            return;
        end
        synced = pipe[0];
        void'(pipe.pop_front());
        pipe.push_back(~k);
        // state machine acts on the previous event and sampled timeup
        ns = m_state;
        c  = 1'b0;
        case (m_state)
            IDLE:  if (m_ev[1]) c = 1'b1; else if (m_ev[0]) ns = RUN;
            RUN:   if (m_tu) ns = DONE; else if (m_ev[0]) ns = PAUSE;
            PAUSE: if (m_ev[1]) begin ns = IDLE; c = 1'b1; end else if (m_ev[0]) ns = RUN;
            default: if (m_ev != 2'b00) begin ns = IDLE; c = 1'b1; end
        endcase
        if (ns == DONE) m_age = (m_state == DONE) ? m_age + 1 : 0;
        // debounce: flip once the last DEB synchronised samples all disagree
        shist.push_back(synced);
        if (shist.size() > DEB) void'(shist.pop_front());
        nstable = m_stable;
        for (int j = 0; j < 2; j++) begin
            all_diff = (shist.size() == DEB);
            foreach (shist[i]) if (shist[i][j] == m_stable[j]) all_diff = 0;
            if (all_diff) nstable[j] = ~m_stable[j];
        end
        m_ev     = m_rose;
        m_rose   = nstable & ~m_stable;
        m_stable = nstable;
        m_tu     = t;
        m_state  = ns;
        m_clr    = c;
    endtask

    task automatic step(input logic r, input logic [1:0] k, input logic t);
        logic exp_alarm;
        @(negedge clk);
        rst_n = r; key_n = k; timeup = t;
        @(posedge clk);
        model_edge(r, k, t);
        #1;
        exp_alarm = (m_state == DONE) ? (((m_age / BLINK) % 2) == 0) : 1'b0;
        chk("state", 32'(state), 32'(m_state));
        chk("run", 32'(run), 32'(m_state == RUN));
        chk("clr", 32'(clr), 32'(m_clr));
        chk("alarm", 32'(alarm), 32'(exp_alarm));
        if (clr === 1'b1) clr_seen++;
    endtask

    // press a key pattern for 'hold' cycles, then release long enough to settle
    task automatic press(input logic [1:0] k, input int hold, input logic t);
        clr_seen = 0;
        for (int i = 0; i < hold; i++) step(1'b1, k, t);
        for (int i = 0; i < DEB + 6; i++) step(1'b1, 2'b11, t);
    endtask

    initial begin
        int blink_exp [7] = '{1, 1, 1, 0, 0, 0, 1};
        int len;
        logic [1:0] k;
        logic t;
        logic r;

        step(1'b0, 2'b11, 1'b0);
        step(1'b0, 2'b11, 1'b0);
        chk("rst_state", 32'(state), 32'(IDLE));
        chk("rst_outs", {29'b0, run, clr, alarm}, 32'd0);

        for (int i = 0; i < 1000; i++) step(1'b1, 2'b11, 1'b0);
        chk("idle_hold", 32'(state), 32'(IDLE));

        // KEY0 low from edge 1: RUN appears exactly after edge DEB+4
        for (int e = 1; e <= DEB + 3; e++) step(1'b1, 2'b10, 1'b0);
        chk("press_early", 32'(state), 32'(IDLE));
        step(1'b1, 2'b10, 1'b0);
        chk("press_lat", 32'(state), 32'(RUN));
        chk("press_run", 32'(run), 32'd1);
        for (int i = 0; i < 100; i++) step(1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 2'b11, 1'b0);
        chk("hold_once", 32'(state), 32'(RUN));

        // glitch shorter than DEB is rejected, DEB-long press pauses
        press(2'b10, DEB - 1, 1'b0);
        chk("glitch", 32'(state), 32'(RUN));
        press(2'b10, DEB, 1'b0);
        chk("glitch_min", 32'(state), 32'(PAUSE));
        press(2'b10, 8, 1'b0);
        chk("resume", 32'(state), 32'(RUN));

        // timeup sampled at edge N -> DONE after edge N+1
        step(1'b1, 2'b11, 1'b1);
        chk("tu_n", 32'(state), 32'(RUN));
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 2'b11, 1'b1);
            if (i == 0) chk("tu_done", 32'(state), 32'(DONE));
            chk("blink", 32'(alarm), 32'(blink_exp[i]));
        end
        press(2'b01, 8, 1'b0);
        chk("done_clr", 32'(state), 32'(IDLE));
        chk("done_clr_cnt", 32'(clr_seen), 32'd1);

        // both keys together: KEY1 wins in PAUSE, KEY0 acts in RUN
        press(2'b10, 8, 1'b0);
        press(2'b10, 8, 1'b0);
        press(2'b00, 8, 1'b0);
        chk("both_pause", 32'(state), 32'(IDLE));
        chk("both_pause_clr", 32'(clr_seen), 32'd1);
        press(2'b10, 8, 1'b0);
        press(2'b00, 8, 1'b0);
        chk("both_run", 32'(state), 32'(PAUSE));
        chk("both_run_clr", 32'(clr_seen), 32'd0);

        // reset in the middle of DONE
        press(2'b10, 8, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 2'b11, 1'b1);
        chk("pre_rst_done", 32'(state), 32'(DONE));
        step(1'b0, 2'b11, 1'b1);
        chk("mid_rst", {28'b0, state, run, alarm}, 32'd0);
        clr_seen = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 2'b11, 1'b0);
        chk("mid_rst_noclr", 32'(clr_seen), 32'd0);

        // random key/timeup traffic
        for (int s = 0; s < 600; s++) begin
            len = $urandom_range(1, 14);
            k   = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            t   = ($urandom_range(0, 5) == 0);
            r   = ($urandom_range(0, 99) != 0);
            if (!r) step(1'b0, k, t);
            for (int i = 0; i < len; i++) step(1'b1, k, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
